// File: rtl/adau_pkg.sv
// Shared types and encodings for the ADAU SPI command arbiter.
package adau_pkg;

  localparam int CMD_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_INIT = 2'd0;
  localparam logic [1:0] GRANT_RT0  = 2'd1;
  localparam logic [1:0] GRANT_RT1  = 2'd2;

endpackage

// File: rtl/adau_spi_arbiter_if.sv
// Handshake bundle: three command requesters on one side, the SPI command stream on the other.
interface adau_spi_arbiter_if
  import adau_pkg::*;
#(
  parameter int CMD_W = CMD_W_DEFAULT
);
  logic [CMD_W-1:0] init_cmd;
  logic             init_valid;
  logic             init_ready;
  logic [CMD_W-1:0] rt0_cmd;
  logic             rt0_valid;
  logic             rt0_ready;
  logic [CMD_W-1:0] rt1_cmd;
  logic             rt1_valid;
  logic             rt1_ready;
  logic [CMD_W-1:0] spi_data;
  logic             spi_valid;
  logic             spi_ready;

  modport master (
    output init_cmd, init_valid, rt0_cmd, rt0_valid, rt1_cmd, rt1_valid, spi_ready,
    input  init_ready, rt0_ready, rt1_ready, spi_data, spi_valid
  );

  modport slave (
    input  init_cmd, init_valid, rt0_cmd, rt0_valid, rt1_cmd, rt1_valid, spi_ready,
    output init_ready, rt0_ready, rt1_ready, spi_data, spi_valid
  );
endinterface

// File: rtl/adau_arb_select.sv
// Combinational grant selection: init first, runtime requesters only once init_done is high.
// With ADAU_ARB_RR_EN defined, rt0/rt1 alternate; otherwise rt0 beats rt1.
module adau_arb_select
  import adau_pkg::*;
(
  input  logic       init_valid,
  input  logic       rt0_valid,
  input  logic       rt1_valid,
  input  logic       init_done,
`ifdef ADAU_ARB_RR_EN
  input  logic       rr_rt1_first,
`endif
  output logic       gnt_valid,
  output logic [1:0] gnt_id
);

  logic rt0_req;
  logic rt1_req;
  logic pick_rt1;

  assign rt0_req = rt0_valid && init_done;
  assign rt1_req = rt1_valid && init_done;

`ifdef ADAU_ARB_RR_EN
  assign pick_rt1 = rt1_req && (!rt0_req || rr_rt1_first);
`else
  assign pick_rt1 = rt1_req && !rt0_req;
`endif

  assign gnt_valid = init_valid || rt0_req || rt1_req;

  always_comb begin
    // NOTE: assign every always_comb output before any branch so no path can infer a latch.
    gnt_id = GRANT_RT0;
    if (init_valid)    gnt_id = GRANT_INIT;
    else if (pick_rt1) gnt_id = GRANT_RT1;
  end

endmodule

// File: rtl/adau_spi_arbiter.sv
// ADAU SPI command arbiter: grants one requester, presents its word to the SPI master, then
// holds off for GAP_CYCLES. Define ADAU_ARB_RR_EN for round-robin between rt0 and rt1.
module adau_spi_arbiter
  import adau_pkg::*;
#(
  parameter int CMD_W      = CMD_W_DEFAULT,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_done,
  adau_spi_arbiter_if.slave bus,
  output logic [1:0]        grant_id,
  output logic              busy
);

  state_t           state_q;
  state_t           state_d;
  logic [CMD_W-1:0] cmd_q;
  logic [CMD_W-1:0] cmd_sel;
  logic [1:0]       grant_q;
  logic [7:0]       gap_q;
  logic             run_q;
  logic             gnt_valid;
  logic [1:0]       gnt_id;
  logic             take;
  logic             accept;

`ifdef ADAU_ARB_RR_EN
  logic rr_rt1_first_q;
`endif

  adau_arb_select u_select (
    .init_valid   (bus.init_valid),
    .rt0_valid    (bus.rt0_valid),
    .rt1_valid    (bus.rt1_valid),
    .init_done    (init_done),
`ifdef ADAU_ARB_RR_EN
    .rr_rt1_first (rr_rt1_first_q),
`endif
    .gnt_valid    (gnt_valid),
    .gnt_id       (gnt_id)
  );

  // run_q is cleared by reset, so no requester sees ready while reset_n is low.
  assign take   = run_q && (state_q == IDLE) && gnt_valid;
  assign accept = (state_q == ISSUE) && bus.spi_ready;

  assign bus.init_ready = take && (gnt_id == GRANT_INIT);
  assign bus.rt0_ready  = take && (gnt_id == GRANT_RT0);
  assign bus.rt1_ready  = take && (gnt_id == GRANT_RT1);
  assign bus.spi_valid  = (state_q == ISSUE);
  assign bus.spi_data   = cmd_q;
  assign grant_id       = grant_q;
  assign busy           = (state_q != IDLE);

  always_comb begin
    cmd_sel = bus.init_cmd;
    case (gnt_id)
      GRANT_RT0: cmd_sel = bus.rt0_cmd;
      GRANT_RT1: cmd_sel = bus.rt1_cmd;
      default:   cmd_sel = bus.init_cmd;
    endcase
  end

  // GAP lasts GAP_CYCLES cycles, so acceptances are GAP_CYCLES+2 apart (ISSUE + GAP + IDLE).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = ISSUE;
      ISSUE:   if (accept) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_q <= 8'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the command register is reset because spi_data must read zero during reset.
    if (!reset_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      grant_q <= GRANT_INIT;
      gap_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (take) begin
        cmd_q   <= cmd_sel;
        grant_q <= gnt_id;
      end
      if (accept) begin
        gap_q <= 8'(GAP_CYCLES);
      end else if ((state_q == GAP) && (gap_q != 8'd0)) begin
        gap_q <= gap_q - 8'd1;
      end
    end
  end

`ifdef ADAU_ARB_RR_EN
  // The runtime requester just granted drops to lowest runtime priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_rt1_first_q <= 1'b0;
    end else if (take && (gnt_id != GRANT_INIT)) begin
      rr_rt1_first_q <= (gnt_id == GRANT_RT0);
    end
  end
`endif

endmodule

// File: tb/tb_adau_spi_arbiter.sv
// Scoreboard bench for adau_spi_arbiter: expected SPI words are queued as stimulus is applied
// and compared on each SPI acceptance; a second instance runs with GAP_CYCLES=0.
module tb_adau_spi_arbiter;
  import adau_pkg::*;

  localparam int G     = 4;
  localparam int CW    = 32;
  localparam int BOUND = 400;

  typedef struct packed {
    logic [1:0]    gid;
    logic [CW-1:0] cmd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       init_done;
  logic [1:0] grant_id;
  logic       busy;
  logic       z_rst_n;
  logic [1:0] z_grant;
  logic       z_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int last_acc = -1;
  bit spacing_on = 1'b0;
  bit g0_done    = 1'b0;

  logic [CW-1:0] rq [3][$];
  logic          fire [3];
  exp_t          sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adau_spi_arbiter_if #(.CMD_W(CW)) bus ();
  adau_spi_arbiter_if #(.CMD_W(CW)) zbus ();

  adau_spi_arbiter #(.CMD_W(CW), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done), .bus(bus),
    .grant_id(grant_id), .busy(busy)
  );

  adau_spi_arbiter #(.CMD_W(CW), .GAP_CYCLES(0)) dut_g0 (
    .clk(clk), .reset_n(z_rst_n), .init_done(1'b1), .bus(zbus),
    .grant_id(z_grant), .busy(z_busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic ready_of(input int r);
    case (r)
      0:       return bus.init_ready;
      1:       return bus.rt0_ready;
      default: return bus.rt1_ready;
    endcase
  endfunction

  function automatic int pending();
    return rq[0].size() + rq[1].size() + rq[2].size();
  endfunction

  task automatic refresh();
    bus.init_valid = (rq[0].size() > 0);
    bus.init_cmd   = (rq[0].size() > 0) ? rq[0][0] : '0;
    bus.rt0_valid  = (rq[1].size() > 0);
    bus.rt0_cmd    = (rq[1].size() > 0) ? rq[1][0] : '0;
    bus.rt1_valid  = (rq[2].size() > 0);
    bus.rt1_cmd    = (rq[2].size() > 0) ? rq[2][0] : '0;
  endtask

  task automatic push_req(input int r, input logic [CW-1:0] cmd);
    rq[r].push_back(cmd);
    refresh();
  endtask

  task automatic expect_cmd(input logic [1:0] gid, input logic [CW-1:0] cmd);
    sb.push_back(exp_t'{gid: gid, cmd: cmd});
  endtask

  // Requester drivers: a word leaves its queue after the edge on which it transferred.
  always @(negedge clk) begin
    fire[0] = bus.init_valid && bus.init_ready;
    fire[1] = bus.rt0_valid && bus.rt0_ready;
    fire[2] = bus.rt1_valid && bus.rt1_ready;
  end

  always @(posedge clk) begin
    #1;
    for (int r = 0; r < 3; r++) begin
      if (fire[r] && rq[r].size() > 0) void'(rq[r].pop_front());
    end
    refresh();
  end

  // SPI-side monitor: every acceptance must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && bus.spi_valid && bus.spi_ready) begin
      exp_t e;
      n_acc++;
      if (sb.size() == 0) begin
        check("sb_extra_issue", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check("spi_data", 64'(bus.spi_data), 64'(e.cmd));
        check("grant_id", 64'(grant_id), 64'(e.gid));
      end
      if (spacing_on && last_acc >= 0) check("spacing", 64'(cyc - last_acc), 64'(G + 2));
      last_acc = cyc;
    end
  end

  task automatic wait_ready(input int r, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!ready_of(r) && n < BOUND);
    check(tag, 64'(ready_of(r)), 64'd1);
  endtask

  task automatic wait_spi_valid(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.spi_valid && n < BOUND);
    check(tag, 64'(bus.spi_valid), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((sb.size() != 0 || busy || pending() != 0) && n < BOUND);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // GAP_CYCLES=0 instance: back-to-back rt1 words must be accepted exactly 2 cycles apart.
  initial begin : g0_run
    int          n     = 0;
    int          z_acc = 0;
    int          z_last = -1;
    logic        zf;
    logic [CW-1:0] z_exp = 32'hA000_0000;
    z_rst_n          = 1'b0;
    zbus.init_valid  = 1'b0;
    zbus.init_cmd    = '0;
    zbus.rt0_valid   = 1'b0;
    zbus.rt0_cmd     = '0;
    zbus.rt1_valid   = 1'b1;
    zbus.rt1_cmd     = 32'hA000_0000;
    zbus.spi_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #2 z_rst_n = 1'b1;
    while (z_acc < 6 && n < BOUND) begin
      @(negedge clk);
      n++;
      zf = zbus.rt1_valid && zbus.rt1_ready;
      if (zbus.spi_valid && zbus.spi_ready) begin
        check("g0_data", 64'(zbus.spi_data), 64'(z_exp));
        check("g0_grant", 64'(z_grant), 64'(GRANT_RT1));
        check("g0_busy", 64'(z_busy), 64'd1);
        if (z_last >= 0) check("g0_spacing", 64'(cyc - z_last), 64'd2);
        z_last = cyc;
        z_exp++;
        z_acc++;
      end
      @(posedge clk);
      #1;
      if (zf) zbus.rt1_cmd = zbus.rt1_cmd + 32'd1;
    end
    check("g0_accepts", 64'(z_acc), 64'd6);
    zbus.rt1_valid = 1'b0;
    g0_done = 1'b1;
  end

  initial begin : main
    int lows;
    int bad;
    int acc_before;
    reset_n = 1'b0;
    init_done = 1'b0;
    bus.spi_ready = 1'b0;
    fire[0] = 1'b0;
    fire[1] = 1'b0;
    fire[2] = 1'b0;
    refresh();

    // Reset state, with an init word already waiting.
    push_req(0, 32'h4000_0001);
    repeat (3) @(negedge clk);
    check("rst_init_ready", 64'(bus.init_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_spi_valid", 64'(bus.spi_valid), 64'd0);
    check("rst_spi_data", 64'(bus.spi_data), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'(GRANT_INIT));

    // Single init command: latency and gap length.
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    bus.spi_ready = 1'b1;
    expect_cmd(GRANT_INIT, 32'h4000_0001);
    wait_ready(0, "init_ready");
    @(negedge clk);
    check("latency_spi_valid", 64'(bus.spi_valid), 64'd1);
    check("latency_init_ready", 64'(bus.init_ready), 64'd0);
    lows = 0;
    for (int k = 0; k < G; k++) begin
      @(negedge clk);
      if (!busy) lows++;
    end
    check("gap_busy_held", 64'(lows), 64'd0);
    @(negedge clk);
    check("gap_busy_released", 64'(busy), 64'd0);

    // Runtime requester held off while init_done is low.
    push_req(1, 32'h1234_0001);
    expect_cmd(GRANT_RT0, 32'h1234_0001);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.rt0_ready || busy) bad++;
    end
    check("gated_rt0_ready", 64'(bad), 64'd0);
    @(posedge clk);
    #2 init_done = 1'b1;
    @(negedge clk);
    check("ungated_rt0_ready", 64'(bus.rt0_ready), 64'd1);
    wait_drain("gated");

    // All three requesters pending at once.
    @(posedge clk);
    #2;
    spacing_on = 1'b1;
    last_acc = -1;
    push_req(0, 32'h4000_0010);
    push_req(0, 32'h4000_0011);
    push_req(1, 32'h5000_0020);
    push_req(1, 32'h5000_0021);
    push_req(2, 32'h6000_0030);
    push_req(2, 32'h6000_0031);
    expect_cmd(GRANT_INIT, 32'h4000_0010);
    expect_cmd(GRANT_INIT, 32'h4000_0011);
`ifdef ADAU_ARB_RR_EN
    // rt0 was the last runtime grant, so rt1 goes first and they alternate.
    expect_cmd(GRANT_RT1, 32'h6000_0030);
    expect_cmd(GRANT_RT0, 32'h5000_0020);
    expect_cmd(GRANT_RT1, 32'h6000_0031);
    expect_cmd(GRANT_RT0, 32'h5000_0021);
`else
    expect_cmd(GRANT_RT0, 32'h5000_0020);
    expect_cmd(GRANT_RT0, 32'h5000_0021);
    expect_cmd(GRANT_RT1, 32'h6000_0030);
    expect_cmd(GRANT_RT1, 32'h6000_0031);
`endif
    wait_drain("prio");
    spacing_on = 1'b0;

    // SPI stall: word held stable, no requester granted meanwhile.
    @(posedge clk);
    #2;
    bus.spi_ready = 1'b0;
    push_req(2, 32'h7000_0040);
    expect_cmd(GRANT_RT1, 32'h7000_0040);
    wait_spi_valid("stall_issue");
    @(posedge clk);
    #2;
    push_req(0, 32'h4000_0050);
    push_req(1, 32'h5000_0051);
    expect_cmd(GRANT_INIT, 32'h4000_0050);
    expect_cmd(GRANT_RT0, 32'h5000_0051);
    bad = 0;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!bus.spi_valid || bus.spi_data !== 32'h7000_0040) bad++;
      if (bus.init_ready || bus.rt0_ready || bus.rt1_ready) lows++;
    end
    check("stall_stable", 64'(bad), 64'd0);
    check("stall_readies", 64'(lows), 64'd0);
    @(posedge clk);
    #2 bus.spi_ready = 1'b1;
    wait_drain("stall");

    // Asynchronous reset while a word sits in ISSUE: it is discarded.
    @(posedge clk);
    #2;
    bus.spi_ready = 1'b0;
    push_req(1, 32'h5000_0060);
    wait_spi_valid("rst_issue");
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_spi_valid", 64'(bus.spi_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_spi_data", 64'(bus.spi_data), 64'd0);
    push_req(2, 32'h6000_0061);
    @(negedge clk);
    check("rst_rt1_ready", 64'(bus.rt1_ready), 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    bus.spi_ready = 1'b1;
    expect_cmd(GRANT_RT1, 32'h6000_0061);
    wait_drain("post_rst");
    check("post_rst_grant_id", 64'(grant_id), 64'(GRANT_RT1));

    // rt1 withdraws while init is being issued: nothing is sent for it.
    @(posedge clk);
    #2;
    acc_before = n_acc;
    push_req(0, 32'h4000_0070);
    push_req(2, 32'h6000_0071);
    expect_cmd(GRANT_INIT, 32'h4000_0070);
    wait_ready(0, "drop_init_ready");
    @(posedge clk);
    #2;
    rq[2].delete();
    refresh();
    wait_drain("drop");
    repeat (10) @(negedge clk);
    check("drop_accepts", 64'(n_acc - acc_before), 64'd1);

    begin
      int n = 0;
      while (!g0_done && n < BOUND) begin @(negedge clk); n++; end
      check("g0_finished", 64'(g0_done), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
